// File: rtl/gf163_pkg.sv
// Shared widths, state encoding and step type for the sequential GF(2^163) multiplier.
package gf163_pkg;

  localparam int FIELD_W = 163;
  localparam int PROD_W  = 325;
  localparam int LIMB_W  = 81;
  localparam int PP_W    = 161;
  localparam int NSTEP   = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  typedef logic [2:0] step_t;

  localparam step_t LAST_STEP = step_t'(NSTEP - 1);

endpackage

// File: rtl/gf163_mul_seq_if.sv
// start/busy/done handshake plus operand and product buses of the multiplier.
interface gf163_mul_seq_if;
  import gf163_pkg::*;

  logic               start;
  logic [FIELD_W-1:0] a;
  logic [FIELD_W-1:0] b;
  logic               busy;
  logic               done;
  logic [PROD_W-1:0]  y;

  modport master (output start, a, b, input busy, done, y);
  modport slave  (input start, a, b, output busy, done, y);

endinterface

// File: rtl/gf163_opsel.sv
// Selects the limb pair fed to the shared ks81 core for each of the six steps.
module gf163_opsel
  import gf163_pkg::*;
(
  input  step_t             step,
  input  logic [LIMB_W-1:0] a0,
  input  logic [LIMB_W-1:0] a1,
  input  logic [LIMB_W-1:0] a2,
  input  logic [LIMB_W-1:0] b0,
  input  logic [LIMB_W-1:0] b1,
  input  logic [LIMB_W-1:0] b2,
  output logic [LIMB_W-1:0] x,
  output logic [LIMB_W-1:0] y
);

  always_comb begin
    x = '0;
    y = '0;
    case (step)
      3'd0: begin x = a0;      y = b0;      end
      3'd1: begin x = a1;      y = b1;      end
      3'd2: begin x = a0 ^ a1; y = b0 ^ b1; end
      3'd3: begin x = a2;      y = b2;      end
      3'd4: begin x = a0 ^ a2; y = b0 ^ b2; end
      3'd5: begin x = a1 ^ a2; y = b1 ^ b2; end
      default: begin x = '0; y = '0; end
    endcase
  end

endmodule

// File: rtl/ks81.sv
// Combinational 81x81 carry-less multiplier producing a 161-bit partial product.
module ks81
  import gf163_pkg::*;
(
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  output logic [PP_W-1:0]   p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < LIMB_W; i++) begin
      if (y[i]) p = p ^ ({{(PP_W-LIMB_W){1'b0}}, x} << i);
    end
  end

endmodule

// File: rtl/overlap_243bit.sv
// Recombines the six 3-way Karatsuba partial products into the unreduced product.
module overlap_243bit
  import gf163_pkg::*;
(
  input  logic [PP_W-1:0]   p0,
  input  logic [PP_W-1:0]   p1,
  input  logic [PP_W-1:0]   p2,
  input  logic [PP_W-1:0]   p3,
  input  logic [PP_W-1:0]   p4,
  input  logic [PP_W-1:0]   p5,
  output logic [PROD_W-1:0] y
);

  localparam int FULL_W = 6 * LIMB_W;

  logic [PP_W-1:0]   t1, t2, t3;
  logic [FULL_W-1:0] full;
  logic              unused_hi;

  // Middle terms: (a0^a1)(b0^b1) ^ a0b0 ^ a1b1 = a0b1 ^ a1b0, etc.
  always_comb begin
    t1   = p2 ^ p0 ^ p1;
    t2   = p4 ^ p0 ^ p3 ^ p1;
    t3   = p5 ^ p1 ^ p3;
    full = '0;
    full[0        +: PP_W] = p0;
    full[LIMB_W   +: PP_W] = full[LIMB_W   +: PP_W] ^ t1;
    full[2*LIMB_W +: PP_W] = full[2*LIMB_W +: PP_W] ^ t2;
    full[3*LIMB_W +: PP_W] = full[3*LIMB_W +: PP_W] ^ t3;
    full[4*LIMB_W +: PP_W] = full[4*LIMB_W +: PP_W] ^ p3;
  end

  // A 163x163 product never reaches bit 325; the top bits are zero whenever
  // all six partial products belong to the same operand pair.
  assign unused_hi = ^full[FULL_W-1:PROD_W];
  assign y         = full[PROD_W-1:0];

endmodule

// File: rtl/gf163_mul_seq.sv
// Sequential GF(2)[x] 163x163 multiplier: one ks81 core reused over six steps,
// 7-clock latency and 8-clock initiation interval behind a start/busy/done handshake.
module gf163_mul_seq
  import gf163_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  gf163_mul_seq_if.slave bus
);

  state_t             state;
  step_t              step;
  logic [FIELD_W-1:0] a_q, b_q;
  logic [PP_W-1:0]    pp [NSTEP];
  logic               busy_q, done_q;
  logic [PROD_W-1:0]  y_q;

  logic [LIMB_W-1:0]  a0, a1, a2, b0, b1, b2;
  logic [LIMB_W-1:0]  op_x, op_y;
  logic [PP_W-1:0]    pk;
  logic [PROD_W-1:0]  prod;

  // Limb split of the zero-extended 243-bit operands; limb 2 holds only bit 162.
  assign a0 = a_q[LIMB_W-1:0];
  assign a1 = a_q[2*LIMB_W-1:LIMB_W];
  assign a2 = {{(LIMB_W-1){1'b0}}, a_q[FIELD_W-1]};
  assign b0 = b_q[LIMB_W-1:0];
  assign b1 = b_q[2*LIMB_W-1:LIMB_W];
  assign b2 = {{(LIMB_W-1){1'b0}}, b_q[FIELD_W-1]};

  gf163_opsel u_opsel (
    .step (step),
    .a0   (a0),
    .a1   (a1),
    .a2   (a2),
    .b0   (b0),
    .b1   (b1),
    .b2   (b2),
    .x    (op_x),
    .y    (op_y)
  );

  ks81 u_ks81 (
    .x (op_x),
    .y (op_y),
    .p (pk)
  );

  overlap_243bit u_overlap (
    .p0 (pp[0]),
    .p1 (pp[1]),
    .p2 (pp[2]),
    .p3 (pp[3]),
    .p4 (pp[4]),
    .p5 (pp[5]),
    .y  (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      y_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      for (int i = 0; i < NSTEP; i++) pp[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            step   <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          pp[step] <= pk;
          step     <= step + step_t'(1);
          if (step == LAST_STEP) state <= OUT;
        end
        OUT: begin
          y_q    <= prod;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          step   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule
